// File: rtl/stereo_downmix_if.sv
// Stereo-to-mono bus: L/R sample strobe in, mono sample and pan measurement out.
// Strobe semantics: new_sample has no ready; the slave accepts the L/R pair on every cycle new_sample is high.
interface stereo_downmix_if;
    logic               new_sample;
    logic signed [15:0] codec_sample_left;
    logic signed [15:0] codec_sample_right;
    logic signed [15:0] codec_sample;
    logic               mono_valid;
    logic [3:0]         pan_level;
    logic               pan_valid;
    logic               pan_silent;
    logic               busy;
    logic [0:0]         state_dbg;

    modport master (
        output new_sample, codec_sample_left, codec_sample_right,
        input  codec_sample, mono_valid, pan_level, pan_valid, pan_silent, busy, state_dbg
    );

    modport slave (
        input  new_sample, codec_sample_left, codec_sample_right,
        output codec_sample, mono_valid, pan_level, pan_valid, pan_silent, busy, state_dbg
    );
endinterface

// File: rtl/stereo_downmix.sv
// Stereo downmix: mono = L+R (saturating when STEREO_DOWNMIX_SAT_EN is defined, wrapping otherwise)
// plus a windowed left-share measurement quantised to 0..8 by a sequential threshold search.
module stereo_downmix #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic             clk,
    input  logic             reset,
    stereo_downmix_if.slave  bus
);
    localparam int AW = 17 + WINDOW_LOG2;
    localparam int CW = 22 + WINDOW_LOG2;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SEARCH = 1'b1;

    logic [0:0]             state;
    logic [2:0]             k;
    logic [AW-1:0]          acc_l, acc_r, snap_l, snap_r;
    logic [WINDOW_LOG2-1:0] cnt;
    logic [16:0]            abs_l, abs_r, sum;
    logic [15:0]            mono;
    logic [CW-1:0]          tot, lhs, rhs;
    logic                   window_end;
    logic [15:0]            codec_sample_q;
    logic [3:0]             pan_level_q;
    logic                   mono_valid_q, pan_valid_q, pan_silent_q;

    always_comb begin
        abs_l = bus.codec_sample_left[15]  ? (17'd0 - {1'b1, bus.codec_sample_left})
                                           : {1'b0, bus.codec_sample_left};
        abs_r = bus.codec_sample_right[15] ? (17'd0 - {1'b1, bus.codec_sample_right})
                                           : {1'b0, bus.codec_sample_right};
        sum   = {bus.codec_sample_left[15], bus.codec_sample_left}
              + {bus.codec_sample_right[15], bus.codec_sample_right};
`ifdef STEREO_DOWNMIX_SAT_EN
        // Sign bits of the 17-bit sum disagree exactly when the 16-bit result overflowed.
        if (sum[16] != sum[15]) begin
            mono = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            mono = sum[15:0];
        end
`else
        mono = sum[15:0];
`endif
        tot        = CW'(snap_l) + CW'(snap_r);
        lhs        = CW'(snap_l) << 4;
        rhs        = CW'({k, 1'b1}) * tot;
        window_end = bus.new_sample && (cnt == '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            acc_l          <= '0;
            acc_r          <= '0;
            snap_l         <= '0;
            snap_r         <= '0;
            cnt            <= '0;
            codec_sample_q <= '0;
            pan_level_q    <= '0;
            mono_valid_q   <= 1'b0;
            pan_valid_q    <= 1'b0;
            pan_silent_q   <= 1'b0;
        end else begin
            mono_valid_q <= 1'b0;
            pan_valid_q  <= 1'b0;
            pan_silent_q <= 1'b0;

            if (state == SEARCH) begin
                if (k == 3'd0 && tot == '0) begin
                    pan_silent_q <= 1'b1;
                    state        <= IDLE;
                end else if (lhs < rhs) begin
                    pan_level_q <= {1'b0, k};
                    pan_valid_q <= 1'b1;
                    state       <= IDLE;
                end else if (k == 3'd7) begin
                    pan_level_q <= 4'd8;
                    pan_valid_q <= 1'b1;
                    state       <= IDLE;
                end else begin
                    k <= k + 3'd1;
                end
            end

            // Accumulation continues during SEARCH; snapshots keep the finished window stable.
            if (bus.new_sample) begin
                codec_sample_q <= mono;
                mono_valid_q   <= 1'b1;
                cnt            <= cnt + 1'b1;
                if (window_end) begin
                    snap_l <= acc_l + AW'(abs_l);
                    snap_r <= acc_r + AW'(abs_r);
                    acc_l  <= '0;
                    acc_r  <= '0;
                    k      <= '0;
                    state  <= SEARCH;
                end else begin
                    acc_l <= acc_l + AW'(abs_l);
                    acc_r <= acc_r + AW'(abs_r);
                end
            end
        end
    end

    assign bus.codec_sample = codec_sample_q;
    assign bus.mono_valid   = mono_valid_q;
    assign bus.pan_level    = pan_level_q;
    assign bus.pan_valid    = pan_valid_q;
    assign bus.pan_silent   = pan_silent_q;
    assign bus.busy         = (state == SEARCH);
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_stereo_downmix.sv
// Bench for stereo_downmix (WINDOW_LOG2=4): directed test-plan cases plus random windows,
// all outputs compared every cycle against a behavioural model of the mono and pan rules.
module tb_stereo_downmix;
    localparam int WL = 4;
    localparam int WIN = 1 << WL;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stereo_downmix_if bus();

    stereo_downmix #(.WINDOW_LOG2(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]        exp_q[$];
    logic               model_ok = 1'b0;
    logic               e_mv, e_pv, e_ps, e_busy;
    logic signed [15:0] e_mono;
    int                 e_lvl;
    longint             sl, sr;
    int                 n, rem, pend_lvl;
    logic               pend_silent;
    int                 pan_pulses = 0;
    int                 mono_pulses = 0;

    function automatic logic signed [15:0] mono_of(input int l, input int r);
        int s;
        s = l + r;
`ifdef STEREO_DOWNMIX_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    always @(posedge clk) begin
        int li, ri;
        longint tot;
        if (reset) begin
            model_ok = 1'b1;
            exp_q.delete();
            e_mv = 0; e_pv = 0; e_ps = 0; e_busy = 0;
            e_mono = 0; e_lvl = 0;
            sl = 0; sr = 0; n = 0; rem = 0;
        end else if (model_ok) begin
            e_mv = 0; e_pv = 0; e_ps = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    if (pend_silent) e_ps = 1;
                    else begin e_pv = 1; e_lvl = pend_lvl; end
                end
            end
            if (bus.new_sample) begin
                li = int'(bus.codec_sample_left);
                ri = int'(bus.codec_sample_right);
                e_mv = 1;
                e_mono = mono_of(li, ri);
                exp_q.push_back(e_mono);
                sl += (li < 0) ? -li : li;
                sr += (ri < 0) ? -ri : ri;
                n++;
                if (n == WIN) begin
                    n = 0;
                    tot = sl + sr;
                    if (tot == 0) begin
                        pend_silent = 1;
                        rem = 1;
                    end else begin
                        pend_silent = 0;
                        pend_lvl = int'((16 * sl + tot) / (2 * tot));
                        rem = (pend_lvl >= 8) ? 8 : pend_lvl + 1;
                    end
                    sl = 0; sr = 0;
                end
            end
            e_busy = (rem > 0);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [15:0] got;
        if (model_ok && !reset) begin
            check("mono_valid", bus.mono_valid, e_mv);
            check("codec_sample", bus.codec_sample, e_mono);
            check("pan_valid", bus.pan_valid, e_pv);
            check("pan_silent", bus.pan_silent, e_ps);
            check("pan_level", bus.pan_level, e_lvl);
            check("busy", bus.busy, e_busy);
            if (bus.mono_valid === 1'b1) begin
                mono_pulses++;
                if (exp_q.size() == 0) check("mono_extra_pulse", 1, 0);
                else begin
                    got = exp_q.pop_front();
                    check("mono_scoreboard", bus.codec_sample, $signed(got));
                end
            end
            if (bus.pan_valid === 1'b1 || bus.pan_silent === 1'b1) pan_pulses++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int l, input int r);
        @(posedge clk); #1;
        bus.codec_sample_left  = 16'(l);
        bus.codec_sample_right = 16'(r);
        bus.new_sample = 1'b1;
        @(posedge clk); #1;
        bus.new_sample = 1'b0;
    endtask

    task automatic send_n(input int l, input int r, input int cnt);
        for (int i = 0; i < cnt; i++) send(l, r);
    endtask

    task automatic wait_pan(output int lat, output logic v, output logic s);
        lat = 0; v = 0; s = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.pan_valid || bus.pan_silent) begin
                lat = i; v = bus.pan_valid; s = bus.pan_silent;
                break;
            end
        end
        if (lat == 0) check("pan_timeout", 0, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.new_sample = i[0];
            bus.codec_sample_left  = 16'($urandom);
            bus.codec_sample_right = 16'($urandom);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.new_sample = 1'b0;
    endtask

    initial begin
        int lat, p0, m0, amp;
        logic v, s;
        bus.new_sample = 1'b0;
        bus.codec_sample_left = '0;
        bus.codec_sample_right = '0;
        repeat (2) @(posedge clk);

        do_reset(3);
        check("rst_codec_sample", bus.codec_sample, 0);
        check("rst_pan_level", bus.pan_level, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mono_valid", bus.mono_valid, 0);
        check("rst_pan_valid", bus.pan_valid, 0);
        check("rst_state", bus.state_dbg, 0);

        // Panner loopback: L=3000 R=5000 -> 8000, pan 3
        send(3000, 5000);
        check("loop_mono_value", bus.codec_sample, 8000);
        check("loop_mono_valid", bus.mono_valid, 1);
        send_n(3000, 5000, WIN - 2);
        repeat (12) @(posedge clk);
        check("first_window_len", pan_pulses, 0);
        send(3000, 5000);
        wait_pan(lat, v, s);
        check("loop_pan_level", bus.pan_level, 3);
        check("loop_pan_valid", v, 1);
        check("loop_latency", lat, 4);

        // Extremes
        send_n(8000, 0, WIN);
        wait_pan(lat, v, s);
        check("ext_left_level", bus.pan_level, 8);
        check("ext_left_latency", lat, 8);
        send_n(0, -500, WIN);
        wait_pan(lat, v, s);
        check("ext_right_level", bus.pan_level, 0);
        check("ext_right_latency", lat, 1);
        send_n(1000, -1000, WIN);
        wait_pan(lat, v, s);
        check("ext_center_level", bus.pan_level, 4);

        // Silence keeps previous level
        send_n(3000, 5000, WIN);
        wait_pan(lat, v, s);
        check("pre_silence_level", bus.pan_level, 3);
        send_n(0, 0, WIN);
        wait_pan(lat, v, s);
        check("silence_pulse", s, 1);
        check("silence_no_valid", v, 0);
        check("silence_level_held", bus.pan_level, 3);
        check("silence_latency", lat, 1);

        // Saturation / wrap
        send(20000, 20000);
`ifdef STEREO_DOWNMIX_SAT_EN
        check("sat_pos", bus.codec_sample, 32767);
`else
        check("wrap_pos", bus.codec_sample, -25536);
`endif
        send(-32768, -32768);
`ifdef STEREO_DOWNMIX_SAT_EN
        check("sat_neg", bus.codec_sample, -32768);
`else
        check("wrap_neg", bus.codec_sample, 0);
`endif

        // Back-to-back strobes for 48 cycles
        do_reset(2);
        p0 = pan_pulses; m0 = mono_pulses;
        @(posedge clk); #1;
        for (int i = 0; i < 3 * WIN; i++) begin
            bus.codec_sample_left  = 16'($urandom);
            bus.codec_sample_right = 16'($urandom);
            bus.new_sample = 1'b1;
            @(posedge clk); #1;
        end
        bus.new_sample = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("b2b_pan_results", pan_pulses - p0, 3);
        check("b2b_mono_count", mono_pulses - m0, 3 * WIN);

        // Reset on the third SEARCH cycle aborts the search
        do_reset(2);
        send_n(700, 100, WIN - 1);
        @(posedge clk); #1;
        bus.codec_sample_left = 16'(700);
        bus.codec_sample_right = 16'(100);
        bus.new_sample = 1'b1;
        @(posedge clk); #1;
        bus.new_sample = 1'b0;
        check("abort_busy_start", bus.busy, 1);
        p0 = pan_pulses;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_pulse", pan_pulses - p0, 0);
        check("abort_pan_level", bus.pan_level, 0);
        check("abort_busy", bus.busy, 0);
        send_n(500, 500, WIN);
        wait_pan(lat, v, s);
        check("post_abort_level", bus.pan_level, 4);

        // Random windows with random gaps and left/right bias
        for (int w = 0; w < 6; w++) begin
            amp = $urandom_range(1, 32767);
            for (int i = 0; i < WIN; i++) begin
                send($urandom_range(0, amp) - (amp / 2) * (w % 2),
                     $urandom_range(0, 32767 - amp) - 16384 * (w % 3 == 0 ? 1 : 0));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        send_n(-32768, -32768, WIN);
        repeat (12) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
